cart_mem_arbiter: RTL

//  Downstream of the cartridge mapper. Takes the mapper's translated PRG and CHR byte accesses
//  and serialises them onto the single cartridge-memory (SDRAM controller) port. One transaction is
//  in flight at a time; a watchdog aborts stalled accesses. Results return to the CPU/PPU side.

---
 rtl/cart_mem_pkg.sv | 16 +
 rtl/cart_mem_slot.sv | 39 +++
 rtl/cart_mem_arbiter.sv | 150 +++++++++++++++
 3 files changed

// File: rtl/cart_mem_pkg.sv
// rtl/cart_mem_pkg.sv - shared types for the cartridge memory arbiter
package cart_mem_pkg;

  localparam int ADDR_W = 22;

  typedef enum logic [1:0] {ST_IDLE, ST_ISSUE, ST_DONE} arb_state_t;
  typedef enum logic {SRC_PRG, SRC_CHR} src_t;

  typedef struct packed {
    logic              valid;
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [7:0]        wdata;
  } slot_t;

endpackage

// File: rtl/cart_mem_slot.sv
// rtl/cart_mem_slot.sv - one-deep request slot with busy detection and sticky overrun
module cart_mem_slot
  import cart_mem_pkg::*;
(
  input  logic              clk,
  input  logic              reset_n,
  input  logic              req,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [7:0]        wdata,
  input  logic              clear,
  input  logic              clr_status,
  output slot_t             slot,
  output logic              overrun
);

  // A slot being retired on this edge is free for a request on the same edge.
  logic busy;
  assign busy = slot.valid && !clear;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      slot    <= '0;
      overrun <= 1'b0;
    end else begin
      if (req && !busy) begin
        slot <= '{valid: 1'b1, we: we, addr: addr, wdata: wdata};
      end else if (clear) begin
        slot.valid <= 1'b0;
      end
      if (req && busy) begin
        overrun <= 1'b1;
      end else if (clr_status) begin
        overrun <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/cart_mem_arbiter.sv
// rtl/cart_mem_arbiter.sv - serialises PRG/CHR byte accesses onto one memory port
module cart_mem_arbiter
  import cart_mem_pkg::*;
#(
  parameter int         TIMEOUT  = 255,
  parameter logic [7:0] OPEN_BUS = 8'hFF
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              prg_req,
  input  logic              prg_we,
  input  logic [ADDR_W-1:0] prg_addr,
  input  logic [7:0]        prg_wdata,
  output logic [7:0]        prg_rdata,
  output logic              prg_done,
  input  logic              chr_req,
  input  logic              chr_we,
  input  logic [ADDR_W-1:0] chr_addr,
  input  logic [7:0]        chr_wdata,
  output logic [7:0]        chr_rdata,
  output logic              chr_done,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_wdata,
  input  logic              mem_ack,
  input  logic [7:0]        mem_rdata,
  output logic              overrun,
  output logic              timeout,
  input  logic              clr_status
);

  localparam int WD_W = (TIMEOUT > 255) ? $clog2(TIMEOUT + 1) : 8;

  arb_state_t      state, state_n;
  src_t            cur_src, last_src, pick;
  slot_t           prg_slot, chr_slot, chosen;
  logic [WD_W-1:0] wd_cnt;
  logic            grant, finish, expire, wd_hit;
  logic            clear_prg, clear_chr, prg_ovr, chr_ovr;
  logic [7:0]      ret_data;

  cart_mem_slot u_prg_slot (
    .clk(clk), .reset_n(reset_n), .req(prg_req), .we(prg_we), .addr(prg_addr),
    .wdata(prg_wdata), .clear(clear_prg), .clr_status(clr_status),
    .slot(prg_slot), .overrun(prg_ovr)
  );

  cart_mem_slot u_chr_slot (
    .clk(clk), .reset_n(reset_n), .req(chr_req), .we(chr_we), .addr(chr_addr),
    .wdata(chr_wdata), .clear(clear_chr), .clr_status(clr_status),
    .slot(chr_slot), .overrun(chr_ovr)
  );

  assign overrun = prg_ovr | chr_ovr;

  // The watchdog fires at the end of the TIMEOUT-th cycle with mem_req high.
  assign wd_hit    = (TIMEOUT != 0) && (wd_cnt == WD_W'(TIMEOUT - 1));
  assign clear_prg = (finish || expire) && (cur_src == SRC_PRG);
  assign clear_chr = (finish || expire) && (cur_src == SRC_CHR);
  assign chosen    = (pick == SRC_CHR) ? chr_slot : prg_slot;
  assign ret_data  = finish ? mem_rdata : OPEN_BUS;

  always_comb begin
    state_n = state;
    grant   = 1'b0;
    finish  = 1'b0;
    expire  = 1'b0;
    if (prg_slot.valid && chr_slot.valid) begin
      pick = (last_src == SRC_PRG) ? SRC_CHR : SRC_PRG;
    end else begin
      pick = chr_slot.valid ? SRC_CHR : SRC_PRG;
    end
    case (state)
      ST_IDLE: begin
        if (prg_slot.valid || chr_slot.valid) begin
          grant   = 1'b1;
          state_n = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        if (mem_ack) begin
          finish  = 1'b1;
          state_n = ST_DONE;
        end else if (wd_hit) begin
          expire  = 1'b1;
          state_n = ST_DONE;
        end
      end
      ST_DONE: state_n = ST_IDLE;
      default: state_n = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_n;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      cur_src   <= SRC_PRG;
      last_src  <= SRC_PRG;
      wd_cnt    <= '0;
      prg_rdata <= OPEN_BUS;
      chr_rdata <= OPEN_BUS;
      prg_done  <= 1'b0;
      chr_done  <= 1'b0;
      timeout   <= 1'b0;
    end else begin
      prg_done <= 1'b0;
      chr_done <= 1'b0;
      if (grant) begin
        mem_req   <= 1'b1;
        mem_we    <= chosen.we;
        mem_addr  <= chosen.addr;
        mem_wdata <= chosen.wdata;
        cur_src   <= pick;
        wd_cnt    <= '0;
      end else if (state == ST_ISSUE) begin
        wd_cnt <= wd_cnt + 1'b1;
      end
      // Aborted accesses also count as served for round-robin fairness.
      if (finish || expire) begin
        mem_req  <= 1'b0;
        last_src <= cur_src;
        if (cur_src == SRC_PRG) begin
          prg_done <= 1'b1;
          if (!mem_we) prg_rdata <= ret_data;
        end else begin
          chr_done <= 1'b1;
          if (!mem_we) chr_rdata <= ret_data;
        end
      end
      if (expire) begin
        timeout <= 1'b1;
      end else if (clr_status) begin
        timeout <= 1'b0;
      end
    end
  end

endmodule
